ecc_dec_apb_ctrl: RTL and testbench

- APB3 slave register bank and operation sequencer directly upstream of the Hamming decoder (DEC).
- Software writes the codeword, an optional noise mask and the codeword-width mode, then triggers an operation.
- The block drives DEC's enable/data_in/work_mod for the required latency, captures data_out/num_of_errors into read-only registers, and pulses operation_done.

---
 rtl/ecc_dec_apb_ctrl_pkg.sv | 26 ++
 rtl/ecc_dec_apb_ctrl_op_seq.sv | 76 +++++++
 rtl/ecc_dec_apb_ctrl.sv | 114 +++++++++++
 tb/tb_ecc_dec_apb_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_dec_apb_ctrl_pkg.sv
// ecc_pkg: constants and types shared by the APB control block of the
// Hamming decoder.
//   - REG_*  : word indices of the register map (PADDR[4:2])
//   - MOD_*  : dec_work_mod encodings for the codeword width
//   - seq_state_e : states of the operation sequencer
package ecc_pkg;

    localparam logic [2:0] REG_CTRL           = 3'd0;  // 0x00
    localparam logic [2:0] REG_DATA_IN        = 3'd1;  // 0x04
    localparam logic [2:0] REG_CODEWORD_WIDTH = 3'd2;  // 0x08
    localparam logic [2:0] REG_NOISE          = 3'd3;  // 0x0C
    localparam logic [2:0] REG_DATA_OUT       = 3'd4;  // 0x10
    localparam logic [2:0] REG_NUM_OF_ERRORS  = 3'd5;  // 0x14

    localparam logic [1:0] MOD_8  = 2'b00;
    localparam logic [1:0] MOD_16 = 2'b01;
    localparam logic [1:0] MOD_32 = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE
    } seq_state_e;

endpackage

// File: rtl/ecc_dec_apb_ctrl_op_seq.sv
// ecc_op_seq: operation sequencer for one decoder pass.
// A start pulse walks IDLE -> ISSUE -> WAIT (DEC_LATENCY-1 cycles) -> CAPTURE.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : one-cycle request, only honoured in IDLE
//   dec_enable  : decoder enable, high in ISSUE/WAIT/CAPTURE
//   capture     : high in CAPTURE; results are latched this cycle
//   busy        : high whenever the sequencer is not IDLE
module ecc_op_seq
    import ecc_pkg::*;
#(
    parameter int DEC_LATENCY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic dec_enable,
    output logic capture,
    output logic busy
);

    // ISSUE already accounts for one cycle of latency, WAIT covers the rest.
    localparam logic [3:0] WAIT_LOAD = 4'(DEC_LATENCY - 1);

    seq_state_e state, state_nxt;
    logic [3:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        dec_enable = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = ISSUE;
            end
            ISSUE: begin
                dec_enable = 1'b1;
                if (DEC_LATENCY == 1) begin
                    state_nxt = CAPTURE;
                end else begin
                    state_nxt = WAIT;
                    cnt_nxt   = WAIT_LOAD;
                end
            end
            WAIT: begin
                dec_enable = 1'b1;
                if (cnt <= 4'd1) begin
                    state_nxt = CAPTURE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            CAPTURE: begin
                dec_enable = 1'b1;
                capture    = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: rtl/ecc_dec_apb_ctrl.sv
// ecc_dec_apb_ctrl: APB3 register bank and sequencer in front of the
// Hamming decoder. Software loads DATA_IN/NOISE/CODEWORD_WIDTH, writes
// CTRL[0]=1, and reads DATA_OUT/NUM_OF_ERRORS after operation_done.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   PADDR..PWDATA, PRDATA, PREADY   : APB3 slave (PADDR[4:2] decoded)
//   dec_enable/dec_data_in/dec_work_mod : decoder request side
//   dec_data_out/dec_num_of_errors  : decoder results
//   operation_done                  : one-cycle pulse at result capture
//   busy                            : sequencer not idle
module ecc_dec_apb_ctrl
    import ecc_pkg::*;
#(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int AMBA_WORD          = 32,
    parameter int AMBA_ADDR_WIDTH    = 20,
    parameter int DEC_LATENCY        = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [AMBA_ADDR_WIDTH-1:0]    PADDR,
    input  logic                          PSEL,
    input  logic                          PENABLE,
    input  logic                          PWRITE,
    input  logic [AMBA_WORD-1:0]          PWDATA,
    output logic [AMBA_WORD-1:0]          PRDATA,
    output logic                          PREADY,
    output logic                          dec_enable,
    output logic [MAX_CODEWORD_WIDTH-1:0] dec_data_in,
    output logic [1:0]                    dec_work_mod,
    input  logic [MAX_CODEWORD_WIDTH-1:0] dec_data_out,
    input  logic [1:0]                    dec_num_of_errors,
    output logic                          operation_done,
    output logic                          busy
);

    localparam int CW = MAX_CODEWORD_WIDTH;

    logic [CW-1:0] data_in_r, noise_r, data_out_r;
    logic [1:0]    cw_r, nerr_r;

    logic       acc, wr_acc, rd_acc, wr_commit, start, capture;
    logic [2:0] reg_idx;

    assign reg_idx = PADDR[4:2];
    assign acc     = PSEL & PENABLE;
    assign wr_acc  = acc & PWRITE;
    assign rd_acc  = acc & ~PWRITE;

    // Writes wait out a running operation so the decoder inputs cannot move
    // under it; reads are always served immediately.
    assign PREADY    = ~(wr_acc & busy);
    assign wr_commit = wr_acc & PREADY;
    assign start     = wr_commit & (reg_idx == REG_CTRL) & PWDATA[0];

    ecc_op_seq #(
        .DEC_LATENCY (DEC_LATENCY)
    ) u_seq (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dec_enable (dec_enable),
        .capture    (capture),
        .busy       (busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            data_in_r  <= '0;
            noise_r    <= '0;
            cw_r       <= MOD_8;
            data_out_r <= '0;
            nerr_r     <= 2'd0;
        end else begin
            if (wr_commit) begin
                case (reg_idx)
                    REG_DATA_IN: data_in_r <= PWDATA[CW-1:0];
                    REG_NOISE:   noise_r   <= PWDATA[CW-1:0];
                    // Encoding 3 has no decoder mode; keep the previous one.
                    REG_CODEWORD_WIDTH: if (PWDATA[1:0] != 2'b11) cw_r <= PWDATA[1:0];
                    default: ;
                endcase
            end
            if (capture) begin
                data_out_r <= dec_data_out;
                nerr_r     <= dec_num_of_errors;
            end
        end
    end

    always_comb begin
        PRDATA = '0;
        if (rd_acc) begin
            case (reg_idx)
                REG_DATA_IN:        PRDATA[CW-1:0] = data_in_r;
                REG_CODEWORD_WIDTH: PRDATA[1:0]    = cw_r;
                REG_NOISE:          PRDATA[CW-1:0] = noise_r;
                REG_DATA_OUT:       PRDATA[CW-1:0] = data_out_r;
                REG_NUM_OF_ERRORS:  PRDATA[1:0]    = nerr_r;
                default: ;
            endcase
        end
    end

    // Noise is applied on the way out to model the channel.
    assign dec_data_in    = data_in_r ^ noise_r;
    assign dec_work_mod   = cw_r;
    assign operation_done = capture;

    // Only PADDR[4:2] and the low PWDATA bits carry meaning.
    logic unused_apb_bits;
    assign unused_apb_bits = ^{PADDR, PWDATA};

endmodule

// File: tb/tb_ecc_dec_apb_ctrl.sv
module tb_ecc_dec_apb_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [19:0] PADDR;
    logic        PSEL, PSEL1, PENABLE, PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA, PRDATA1;
    logic        PREADY, PREADY1;
    logic        dec_enable, dec_enable1;
    logic [31:0] dec_data_in, dec_data_in1, dec_data_out, dec_data_out1;
    logic [1:0]  dec_work_mod, dec_work_mod1, dec_nerr, dec_nerr1;
    logic        operation_done, operation_done1, busy, busy1;

    ecc_dec_apb_ctrl #(.DEC_LATENCY(2)) u_dut (
        .clk(clk), .rst(rst), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .dec_enable(dec_enable), .dec_data_in(dec_data_in), .dec_work_mod(dec_work_mod),
        .dec_data_out(dec_data_out), .dec_num_of_errors(dec_nerr),
        .operation_done(operation_done), .busy(busy));

    ecc_dec_apb_ctrl #(.DEC_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .PADDR(PADDR), .PSEL(PSEL1), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA1), .PREADY(PREADY1),
        .dec_enable(dec_enable1), .dec_data_in(dec_data_in1), .dec_work_mod(dec_work_mod1),
        .dec_data_out(dec_data_out1), .dec_num_of_errors(dec_nerr1),
        .operation_done(operation_done1), .busy(busy1));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Decoder stubs: result reflects the data presented DEC_LATENCY cycles
    // earlier while enabled, zero otherwise.
    function automatic logic [31:0] stub_data(input logic [31:0] x);
        return (x == 32'h13) ? 32'h0000_0ABC : ~x;
    endfunction
    function automatic logic [1:0] stub_err(input logic [31:0] x);
        return (x == 32'h13) ? 2'd1 : 2'd2;
    endfunction

    logic [31:0] s0_d1, s0_d2, s1_d;
    logic [1:0]  s0_e1, s0_e2;
    always @(posedge clk) begin
        s0_d1 <= dec_enable ? stub_data(dec_data_in) : 32'h0;
        s0_e1 <= dec_enable ? stub_err(dec_data_in) : 2'd0;
        s0_d2 <= s0_d1;
        s0_e2 <= s0_e1;
        s1_d  <= dec_enable1 ? dec_data_in1 + 32'h100 : 32'h0;
    end
    assign dec_data_out  = s0_d2;
    assign dec_nerr      = s0_e2;
    assign dec_data_out1 = s1_d;
    assign dec_nerr1     = 2'd3;

    typedef struct { string name; logic [31:0] exp; } rd_t;
    typedef struct { int t; int done; logic [31:0] din; } op_t;
    rd_t rd_q[$];
    op_t op_q[$], op1_q[$];
    int n_cmp = 0, n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Read monitor: every completed read access is matched against the queue.
    always @(negedge clk) begin
        rd_t e;
        if (PSEL && PENABLE && !PWRITE && PREADY) begin
            if (rd_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_read: PRDATA %h with no expectation", PRDATA);
            end else begin
                e = rd_q.pop_front();
                chk(e.name, PRDATA, e.exp);
            end
        end
    end

    // Operation monitors: data stability while enabled, done timing, enable length.
    int run0 = 0, run1 = 0;
    always @(negedge clk) begin
        op_t e;
        if (dec_enable) begin
            run0++;
            if (op_q.size() > 0) chk("dec_data_in", dec_data_in, op_q[0].din);
        end
        if (operation_done) begin
            if (op_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_done: pulse at cycle %0d, none expected", cyc);
            end else begin
                e = op_q.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e.done));
                chk("enable_cycles", 32'(run0), 32'(e.done - e.t));
            end
        end
        if (!dec_enable) run0 = 0;
    end

    always @(negedge clk) begin
        op_t e;
        if (dec_enable1) begin
            run1++;
            if (op1_q.size() > 0) chk("lat1_dec_data_in", dec_data_in1, op1_q[0].din);
        end
        if (operation_done1) begin
            if (op1_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL lat1_unexpected_done: pulse at cycle %0d, none expected", cyc);
            end else begin
                e = op1_q.pop_front();
                chk("lat1_done_cycle", 32'(cyc), 32'(e.done));
                chk("lat1_enable_cycles", 32'(run1), 32'(e.done - e.t));
            end
        end
        if (!dec_enable1) run1 = 0;
    end

    // All tasks start and end at #1 after a rising edge.
    task automatic apb_wr(input bit to1, input logic [19:0] a, input logic [31:0] d,
                          output int tc, output int st);
        PADDR = a; PWDATA = d; PWRITE = 1'b1; PENABLE = 1'b0;
        if (to1) PSEL1 = 1'b1; else PSEL = 1'b1;
        @(posedge clk); #1 PENABLE = 1'b1;
        st = 0; tc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (to1 ? PREADY1 : PREADY) begin tc = cyc; break; end
            st++;
            @(posedge clk); #1;
        end
        if (tc < 0) begin
            n_cmp++; n_err++;
            $display("FAIL apb_write_timeout: addr %h never got PREADY", a);
        end
        @(posedge clk); #1;
        PSEL = 1'b0; PSEL1 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_rd(input logic [19:0] a, input logic [31:0] exp, input string nm);
        rd_t e;
        bit ok;
        e.name = nm; e.exp = exp;
        rd_q.push_back(e);
        PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
        @(posedge clk); #1 PENABLE = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (PREADY) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL apb_read_timeout: addr %h never got PREADY", a);
        end
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic op_t mk_op(input int t, input int lat, input logic [31:0] din);
        op_t o;
        o.t = t; o.done = t + lat + 1; o.din = din;
        return o;
    endfunction

    initial begin
        int t, s, t2, s2;
        rst = 1'b1; PSEL = 1'b0; PSEL1 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pready", 32'(PREADY), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dec_enable", 32'(dec_enable), 32'd0);
        chk("rst_done", 32'(operation_done), 32'd0);
        chk("rst_prdata", PRDATA, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i <= 6; i++) apb_rd(20'(i * 4), 32'h0, $sformatf("reset_read_%02h", i * 4));

        // Codeword width: 3 is rejected, earlier value remains
        apb_wr(0, 20'h08, 32'h1, t, s);
        apb_wr(0, 20'h08, 32'h3, t, s);
        apb_rd(20'h08, 32'h1, "cw_keep_after_3");
        @(negedge clk); chk("dec_work_mod", 32'(dec_work_mod), 32'd1);
        @(posedge clk); #1;
        apb_wr(0, 20'h04, 32'hDEAD_BEEF, t, s);
        apb_rd(20'h04, 32'hDEAD_BEEF, "data_in_rb");

        // CTRL[0]=0 starts nothing
        apb_wr(0, 20'h00, 32'h2, t, s);
        @(negedge clk); chk("no_start_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        apb_rd(20'h00, 32'h0, "ctrl_reads_0");

        // Basic operation: 0x12 ^ 0x01 = 0x13
        apb_wr(0, 20'h04, 32'h12, t, s);
        apb_wr(0, 20'h0C, 32'h01, t, s);
        apb_wr(0, 20'h00, 32'h1, t, s);
        op_q.push_back(mk_op(t, 2, 32'h13));
        idle(4);
        apb_rd(20'h10, 32'h0000_0ABC, "data_out_1");
        apb_rd(20'h14, 32'h1, "num_err_1");

        // Write during busy stalls until IDLE
        apb_wr(0, 20'h00, 32'h1, t, s);
        op_q.push_back(mk_op(t, 2, 32'h13));
        apb_wr(0, 20'h0C, 32'hFF, t2, s2);
        chk("stall_commit_cycle", 32'(t2), 32'(t + 4));
        chk("stall_cycles", 32'(s2), 32'd2);
        apb_rd(20'h0C, 32'hFF, "noise_after_stall");
        apb_rd(20'h10, 32'h0000_0ABC, "data_out_2");

        // Second pattern: 0x12 ^ 0x02 = 0x10, stub returns ~0x10, 2 errors
        apb_wr(0, 20'h0C, 32'h02, t, s);
        apb_wr(0, 20'h00, 32'h1, t, s);
        op_q.push_back(mk_op(t, 2, 32'h10));
        idle(4);
        apb_rd(20'h10, 32'hFFFF_FFEF, "data_out_3");
        apb_rd(20'h14, 32'h2, "num_err_3");

        // Reset in the middle of an operation
        apb_wr(0, 20'h00, 32'h1, t, s);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_dec_enable", 32'(dec_enable), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(operation_done), 32'd0);
        @(posedge clk); #1;
        idle(3);
        apb_rd(20'h10, 32'h0, "midrst_data_out");
        apb_rd(20'h14, 32'h0, "midrst_num_err");
        apb_rd(20'h04, 32'h0, "midrst_data_in");
        apb_rd(20'h08, 32'h0, "midrst_cw");

        // DEC_LATENCY=1 instance
        apb_wr(1, 20'h04, 32'h5, t, s);
        apb_wr(1, 20'h00, 32'h1, t, s);
        op1_q.push_back(mk_op(t, 1, 32'h5));
        idle(4);

        // Unmapped offset: write ignored, reads 0
        apb_wr(0, 20'h18, 32'hFFFF_FFFF, t, s);
        apb_rd(20'h18, 32'h0, "unmapped_read");
        apb_rd(20'h04, 32'h0, "unmapped_no_alias_data_in");
        apb_rd(20'h0C, 32'h0, "unmapped_no_alias_noise");

        idle(2);
        chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
        chk("op_q_drained", 32'(op_q.size()), 32'd0);
        chk("op1_q_drained", 32'(op1_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d compared", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
